vlsu: RTL

Vector load/store unit for the 5-lane vector datapath. It moves a vector of up to 5 32-bit lanes between the vector register file and the 32-bit data memory port, one word per accepted memory handshake. On a load it gathers consecutive words into a lane buffer and hands the assembled vector to register-file writeback. On a store it serializes the register-file read vector into consecutive word writes. The block sits beside the vector ALU: same lane count and active-lane count semantics, but on the memory side of the vector register file.

---
 rtl/vlsu.sv | 102 ++++++++++
 1 files changed

// File: rtl/vlsu.sv
// vlsu: vector load/store unit moving up to 5 lanes between the vector register file and a 32-bit memory port
module vlsu #(
    parameter int LANES = 5,
    parameter int CW    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                is_store,
    input  logic [31:0]         base_addr,
    input  logic [CW-1:0]       len,
    input  logic [32*LANES-1:0] VWriteData,
    output logic                MemReq,
    output logic                MemWrite,
    output logic [31:0]         MemAddr,
    output logic [31:0]         MemWData,
    input  logic [31:0]         MemRData,
    input  logic                MemReady,
    output logic [32*LANES-1:0] VReadData,
    output logic                VRegWrite,
    output logic                busy,
    output logic                done
);
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
    localparam logic [CW-1:0] MAXLEN = CW'(LANES);
    state_t              state_q;
    logic                store_q, req_q, done_q, vwe_q;
    logic [CW-1:0]       len_q, cnt_q, len_d, cnt_d;
    logic [31:0]         addr_q, wd_q;
    logic [32*LANES-1:0] wdata_q, vdata_q;

    // clamp the requested lane count and precompute the next lane index
    always_comb begin
        len_d = (len > MAXLEN) ? MAXLEN : len;
        cnt_d = cnt_q + CW'(1);
    end

    // transfer FSM; memory-side and writeback outputs are held in registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            store_q <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
            wdata_q <= '0;
            vdata_q <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            vwe_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    store_q <= is_store;
                    len_q   <= len_d;
                    cnt_q   <= '0;
                    wdata_q <= VWriteData;
                    if (!is_store) vdata_q <= '0;
                    if (len_d == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= XFER;
                        req_q   <= 1'b1;
                        addr_q  <= base_addr;
                        wd_q    <= VWriteData[31:0];
                    end
                end
                XFER: if (MemReady) begin
                    if (!store_q) vdata_q[{cnt_q, 5'd0} +: 32] <= MemRData;
                    if (cnt_q == len_q - CW'(1)) begin
                        state_q <= DONE;
                        req_q   <= 1'b0;
                        addr_q  <= '0;
                        wd_q    <= '0;
                        done_q  <= 1'b1;
                        vwe_q   <= !store_q;
                    end else begin
                        cnt_q  <= cnt_d;
                        addr_q <= addr_q + 32'd4;
                        wd_q   <= wdata_q[{cnt_d, 5'd0} +: 32];
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    vwe_q   <= 1'b0;
                end
            endcase
        end
    end

    assign MemReq    = req_q;
    assign MemWrite  = req_q & store_q;
    assign MemAddr   = addr_q;
    assign MemWData  = wd_q;
    assign VReadData = vdata_q;
    assign VRegWrite = vwe_q;
    assign done      = done_q;
    assign busy      = state_q != IDLE;
endmodule
